// File: rtl/bp_common_cfg_link_pkg.sv
// Shared definitions for the config link: default widths, register address map
// and the endpoint FSM state encoding.
package bp_common_cfg_link_pkg;

  typedef struct packed {
    int unsigned cfg_core_width;
    int unsigned cfg_addr_width;
    int unsigned cfg_data_width;
  } bp_proc_param_s;

  localparam bp_proc_param_s bp_default_cfg_gp = '{
    cfg_core_width: 8,
    cfg_addr_width: 16,
    cfg_data_width: 64
  };

  localparam logic [15:0] cfg_addr_freeze_gp       = 16'h0000;
  localparam logic [15:0] cfg_addr_core_id_gp      = 16'h0001;
  localparam logic [15:0] cfg_addr_scratch_base_gp = 16'h0010;

  typedef enum logic {
    e_ready = 1'b0,
    e_resp  = 1'b1
  } bp_cfg_state_e;

endpackage

// File: rtl/bsg_dff_reset_en.sv
// Enabled D flip-flop bank with synchronous active-high reset to a fixed value.
module bsg_dff_reset_en #(
  parameter int unsigned         width_p     = 1,
  parameter logic [width_p-1:0]  reset_val_p = '0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_q <= reset_val_p;
    end else if (en_i) begin
      data_q <= data_i;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/bp_cfg_endpoint.sv
// Per-core configuration endpoint: freeze bit, read-only core ID and scratch
// registers behind a valid/ready request port with a held read response.
module bp_cfg_endpoint
  import bp_common_cfg_link_pkg::*;
#(
  parameter int unsigned cfg_core_width_p = bp_default_cfg_gp.cfg_core_width,
  parameter int unsigned cfg_addr_width_p = bp_default_cfg_gp.cfg_addr_width,
  parameter int unsigned cfg_data_width_p = bp_default_cfg_gp.cfg_data_width,
  parameter int unsigned num_scratch_p    = 4,
  parameter int unsigned core_id_p        = 0
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,

  input  logic                                      cfg_v_i,
  input  logic                                      cfg_w_i,
  input  logic [cfg_core_width_p-1:0]               cfg_core_i,
  input  logic [cfg_addr_width_p-1:0]               cfg_addr_i,
  input  logic [cfg_data_width_p-1:0]               cfg_data_i,
  output logic                                      cfg_ready_o,

  output logic                                      resp_v_o,
  output logic [cfg_data_width_p-1:0]               resp_data_o,
  input  logic                                      resp_yumi_i,

  output logic                                      freeze_o,
  output logic [num_scratch_p*cfg_data_width_p-1:0] scratch_o
);

  localparam logic [cfg_core_width_p-1:0] core_id_lp = cfg_core_width_p'(core_id_p);
  localparam logic [cfg_core_width_p-1:0] core_bc_lp = '1;

  bp_cfg_state_e state_q, state_d;

  logic                                          accept;
  logic                                          id_match, bc_match;
  logic                                          wr_acc, rd_acc;
  logic                                          freeze_hit, core_id_hit;
  logic [num_scratch_p-1:0]                      scratch_hit;
  logic [num_scratch_p-1:0]                      scratch_we;
  logic [num_scratch_p-1:0][cfg_data_width_p-1:0] scratch_q;
  logic                                          freeze_q, freeze_d;
  logic [cfg_data_width_p-1:0]                   resp_data_q, resp_data_d;

  // Acceptance is derived from the state register directly so the ready output
  // logic never feeds back into itself through the request decode.
  assign accept   = cfg_v_i && (state_q == e_ready) && !reset_i;
  assign id_match = (cfg_core_i == core_id_lp);
  assign bc_match = (cfg_core_i == core_bc_lp);
  assign wr_acc   = accept && cfg_w_i && (id_match || bc_match);
  assign rd_acc   = accept && !cfg_w_i && id_match;

  assign freeze_hit  = (cfg_addr_i == cfg_addr_width_p'(cfg_addr_freeze_gp));
  assign core_id_hit = (cfg_addr_i == cfg_addr_width_p'(cfg_addr_core_id_gp));

  always_comb begin
    scratch_hit = '0;
    scratch_we  = '0;
    for (int unsigned i = 0; i < num_scratch_p; i++) begin
      scratch_hit[i] = (cfg_addr_i == cfg_addr_width_p'(32'(cfg_addr_scratch_base_gp) + i));
      scratch_we[i]  = wr_acc && scratch_hit[i];
    end
  end

  always_comb begin
    resp_data_d = '0;
    if (freeze_hit) begin
      resp_data_d[0] = freeze_q;
    end
    if (core_id_hit) begin
      resp_data_d = cfg_data_width_p'(core_id_p);
    end
    for (int unsigned i = 0; i < num_scratch_p; i++) begin
      if (scratch_hit[i]) begin
        resp_data_d = scratch_q[i];
      end
    end
  end

  assign freeze_d = cfg_data_i[0];

  bsg_dff_reset_en #(
    .width_p     (1),
    .reset_val_p (1'b1)
  ) u_freeze (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (wr_acc && freeze_hit),
    .data_i  (freeze_d),
    .data_o  (freeze_q)
  );

  for (genvar g = 0; g < num_scratch_p; g++) begin : g_scratch
    bsg_dff_reset_en #(
      .width_p     (cfg_data_width_p),
      .reset_val_p ('0)
    ) u_scratch (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .en_i    (scratch_we[g]),
      .data_i  (cfg_data_i),
      .data_o  (scratch_q[g])
    );
  end

  bsg_dff_reset_en #(
    .width_p     (cfg_data_width_p),
    .reset_val_p ('0)
  ) u_resp_data (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (rd_acc),
    .data_i  (resp_data_d),
    .data_o  (resp_data_q)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_ready;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cfg_ready_o = 1'b0;
    resp_v_o    = 1'b0;
    case (state_q)
      e_ready: begin
        cfg_ready_o = !reset_i;
        if (rd_acc) begin
          state_d = e_resp;
        end
      end
      e_resp: begin
        resp_v_o = !reset_i;
        if (resp_yumi_i) begin
          state_d = e_ready;
        end
      end
      default: state_d = e_ready;
    endcase
  end

  assign resp_data_o = resp_data_q;
  assign freeze_o    = freeze_q;
  assign scratch_o   = scratch_q;

endmodule

// File: tb/tb_bp_cfg_endpoint.sv
// Directed bench for bp_cfg_endpoint with a read-response scoreboard.
module tb_bp_cfg_endpoint;

  localparam int unsigned CW   = 8;
  localparam int unsigned AW   = 16;
  localparam int unsigned DW   = 64;
  localparam int unsigned NS   = 4;
  localparam int unsigned CORE = 3;

  logic             clk_i;
  logic             reset_i;
  logic             cfg_v_i;
  logic             cfg_w_i;
  logic [CW-1:0]    cfg_core_i;
  logic [AW-1:0]    cfg_addr_i;
  logic [DW-1:0]    cfg_data_i;
  logic             cfg_ready_o;
  logic             resp_v_o;
  logic [DW-1:0]    resp_data_o;
  logic             resp_yumi_i;
  logic             freeze_o;
  logic [NS*DW-1:0] scratch_o;

  int checks;
  int errors;
  logic [DW-1:0] exp_q[$];

  bp_cfg_endpoint #(
    .cfg_core_width_p (CW),
    .cfg_addr_width_p (AW),
    .cfg_data_width_p (DW),
    .num_scratch_p    (NS),
    .core_id_p        (CORE)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .cfg_v_i     (cfg_v_i),
    .cfg_w_i     (cfg_w_i),
    .cfg_core_i  (cfg_core_i),
    .cfg_addr_i  (cfg_addr_i),
    .cfg_data_i  (cfg_data_i),
    .cfg_ready_o (cfg_ready_o),
    .resp_v_o    (resp_v_o),
    .resp_data_o (resp_data_o),
    .resp_yumi_i (resp_yumi_i),
    .freeze_o    (freeze_o),
    .scratch_o   (scratch_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic w, input logic [CW-1:0] core,
                      input logic [AW-1:0] addr, input logic [DW-1:0] data);
    cfg_v_i    = 1'b1;
    cfg_w_i    = w;
    cfg_core_i = core;
    cfg_addr_i = addr;
    cfg_data_i = data;
    tick();
    cfg_v_i    = 1'b0;
  endtask

  // Called one cycle after a matching read was accepted.
  task automatic take_resp(input string tag);
    chk({tag, " resp_v"}, DW'(resp_v_o), 1);
    chk({tag, " pending"}, DW'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      chk({tag, " data"}, resp_data_o, exp_q.pop_front());
    end
    resp_yumi_i = 1'b1;
    tick();
    resp_yumi_i = 1'b0;
    chk({tag, " resp_v after yumi"}, DW'(resp_v_o), 0);
    chk({tag, " ready after yumi"}, DW'(cfg_ready_o), 1);
  endtask

  function automatic logic [DW-1:0] scratch(input int unsigned idx);
    return scratch_o[idx*DW +: DW];
  endfunction

  initial begin
    checks      = 0;
    errors      = 0;
    reset_i     = 1'b1;
    cfg_v_i     = 1'b0;
    cfg_w_i     = 1'b0;
    cfg_core_i  = '0;
    cfg_addr_i  = '0;
    cfg_data_i  = '0;
    resp_yumi_i = 1'b0;

    tick();
    tick();
    chk("rst ready", DW'(cfg_ready_o), 0);
    chk("rst resp_v", DW'(resp_v_o), 0);
    chk("rst resp_data", resp_data_o, 0);
    chk("rst freeze", DW'(freeze_o), 1);
    for (int i = 0; i < NS; i++) chk("rst scratch", scratch(i), 0);

    reset_i = 1'b0;
    #1;
    chk("ready after reset", DW'(cfg_ready_o), 1);

    // Freeze reads back as 1 out of reset.
    exp_q.push_back(64'd1);
    send(1'b0, CW'(CORE), 16'h0000, '0);
    take_resp("rd freeze init");

    // Clearing freeze is visible the cycle after the write; no response.
    send(1'b1, CW'(CORE), 16'h0000, 64'd0);
    chk("freeze after write", DW'(freeze_o), 0);
    chk("no resp on write", DW'(resp_v_o), 0);
    chk("ready after write", DW'(cfg_ready_o), 1);
    exp_q.push_back(64'd0);
    send(1'b0, CW'(CORE), 16'h0000, '0);
    take_resp("rd freeze cleared");

    // Broadcast write lands; broadcast read is dropped.
    send(1'b1, 8'hFF, 16'h0012, 64'hDEADBEEF);
    chk("bcast wr scratch2", scratch(2), 64'hDEADBEEF);
    send(1'b0, 8'hFF, 16'h0012, '0);
    for (int i = 0; i < 3; i++) begin
      chk("bcast rd no resp", DW'(resp_v_o), 0);
      chk("bcast rd ready", DW'(cfg_ready_o), 1);
      tick();
    end

    // Write to another core is ignored.
    send(1'b1, 8'd5, 16'h0011, 64'h123);
    chk("other core wr scratch1", scratch(1), 0);

    // Held response: stable data, no acceptance while waiting.
    send(1'b1, CW'(CORE), 16'h0010, 64'h0123_4567_89AB_CDEF);
    chk("wr scratch0", scratch(0), 64'h0123_4567_89AB_CDEF);
    exp_q.push_back(64'h0123_4567_89AB_CDEF);
    send(1'b0, CW'(CORE), 16'h0010, '0);
    for (int i = 0; i < 5; i++) begin
      chk("hold resp_v", DW'(resp_v_o), 1);
      chk("hold data", resp_data_o, exp_q[0]);
      chk("hold ready", DW'(cfg_ready_o), 0);
      cfg_v_i    = 1'b1;
      cfg_w_i    = 1'b1;
      cfg_core_i = CW'(CORE);
      cfg_addr_i = 16'h0000;
      cfg_data_i = 64'd1;
      tick();
    end
    cfg_v_i = 1'b0;
    take_resp("rd scratch0 held");
    chk("freeze unchanged while busy", DW'(freeze_o), 0);

    // Core ID is read-only; unmapped addresses read zero.
    send(1'b1, CW'(CORE), 16'h0001, 64'd7);
    exp_q.push_back(64'(CORE));
    send(1'b0, CW'(CORE), 16'h0001, '0);
    take_resp("rd core id");
    exp_q.push_back(64'd0);
    send(1'b0, CW'(CORE), 16'h0100, '0);
    take_resp("rd unmapped 0x100");
    send(1'b1, CW'(CORE), 16'h0014, 64'hFFFF);
    exp_q.push_back(64'd0);
    send(1'b0, CW'(CORE), 16'h0014, '0);
    take_resp("rd past scratch");
    send(1'b1, CW'(CORE), 16'h0013, 64'hA5A5_0000_5A5A);
    exp_q.push_back(64'hA5A5_0000_5A5A);
    send(1'b0, CW'(CORE), 16'h0013, '0);
    take_resp("rd scratch3");
    exp_q.push_back(64'hDEADBEEF);
    send(1'b0, CW'(CORE), 16'h0012, '0);
    take_resp("rd scratch2");

    // Reset while a response is pending discards it.
    exp_q.push_back(64'd0);
    send(1'b0, CW'(CORE), 16'h0000, '0);
    chk("pre-reset resp_v", DW'(resp_v_o), 1);
    reset_i = 1'b1;
    tick();
    exp_q.delete();
    chk("reset in resp resp_v", DW'(resp_v_o), 0);
    chk("reset in resp freeze", DW'(freeze_o), 1);
    chk("reset in resp ready", DW'(cfg_ready_o), 0);
    chk("reset in resp scratch0", scratch(0), 0);
    chk("reset in resp data", resp_data_o, 0);
    reset_i = 1'b0;
    #1;
    chk("ready after 2nd reset", DW'(cfg_ready_o), 1);
    tick();
    chk("no stale resp", DW'(resp_v_o), 0);
    chk("scoreboard drained", DW'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
